retire_trace_buf: RTL and testbench

Captures every instruction retired by the pipeline's write-back stage (PC, encoding, type, destination register and written value) and buffers it in a FIFO. The buffered entries stream to the co-simulation checker over a valid/ready interface. The block sits directly downstream of write-back, between the `top` core and the DPI reference-model comparator. It also owns end-of-simulation detection (exit syscall) and overflow reporting, so the bench no longer samples pipeline internals.

---
 rtl/retire_trace_buf_if.sv | 49 ++++
 rtl/retire_trace_buf.sv | 147 ++++++++++++++
 tb/tb_retire_trace_buf.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_buf_if.sv
// Retire/trace bundle between write-back, retire_trace_buf and the co-sim checker.
// trc_cycle_o exists only when RETIRE_TRACE_TIMESTAMP_EN is defined.
interface retire_trace_buf_if #(
  parameter int CNT_W = 32
);
  logic             ret_valid_i;
  logic [31:0]      ret_pc_i;
  logic [31:0]      ret_instr_i;
  logic             ret_is_r_i;
  logic             ret_is_i_i;
  logic [4:0]       ret_dest_i;
  logic [31:0]      ret_dest_val_i;
  logic [31:0]      ret_v0_i;
  logic             trc_ready_i;
  logic             trc_valid_o;
  logic [31:0]      trc_pc_o;
  logic [31:0]      trc_instr_o;
  logic [31:0]      trc_dest_val_o;
  logic [4:0]       trc_dest_o;
  logic [1:0]       trc_type_o;
  logic             stall_o;
  logic             overflow_o;
  logic             type_err_o;
  logic             eos_o;
  logic [CNT_W-1:0] retire_cnt_o;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
  logic [31:0]      trc_cycle_o;
`endif

  modport slave (
    input  ret_valid_i, ret_pc_i, ret_instr_i, ret_is_r_i, ret_is_i_i,
           ret_dest_i, ret_dest_val_i, ret_v0_i, trc_ready_i,
    output trc_valid_o, trc_pc_o, trc_instr_o, trc_dest_val_o, trc_dest_o,
           trc_type_o, stall_o, overflow_o, type_err_o, eos_o, retire_cnt_o
`ifdef RETIRE_TRACE_TIMESTAMP_EN
         , trc_cycle_o
`endif
  );

  modport master (
    output ret_valid_i, ret_pc_i, ret_instr_i, ret_is_r_i, ret_is_i_i,
           ret_dest_i, ret_dest_val_i, ret_v0_i, trc_ready_i,
    input  trc_valid_o, trc_pc_o, trc_instr_o, trc_dest_val_o, trc_dest_o,
           trc_type_o, stall_o, overflow_o, type_err_o, eos_o, retire_cnt_o
`ifdef RETIRE_TRACE_TIMESTAMP_EN
         , trc_cycle_o
`endif
  );
endinterface

// File: rtl/retire_trace_buf.sv
// Retired-instruction trace FIFO with back-pressure, overflow/type flags and exit-syscall EOS.
// Optional RETIRE_TRACE_TIMESTAMP_EN adds a captured cycle stamp per entry (trc_cycle_o).
module retire_trace_buf #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  retire_trace_buf_if.slave bus
);
  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   STALL_CNT  = (PTR_W+1)'(DEPTH-2);
  localparam logic [31:0]      EXIT_INSTR = 32'h0000000c;
  localparam logic [31:0]      EXIT_V0    = 32'h0000000a;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  typ;
    logic [4:0]  dest;
    logic [31:0] val;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [31:0] cyc;
`endif
  } entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  entry_t           mem [DEPTH];
  entry_t           entry_in;
  entry_t           head;
  logic [PTR_W-1:0] rptr, wptr;
  logic [PTR_W:0]   count, count_next;
  state_t           state, state_next;
  logic             full, empty, pop, push, drop, is_exit, bad_type, eos;
  logic             stall, overflow, type_err;
  logic [CNT_W-1:0] retire_cnt;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
  logic [31:0]      cyc_cnt;
`endif

  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    pop      = !empty && bus.trc_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push     = bus.ret_valid_i && (state == RUN) && (!full || pop);
    drop     = bus.ret_valid_i && (state == RUN) && full && !pop;
    is_exit  = push && (bus.ret_instr_i == EXIT_INSTR) && (bus.ret_v0_i == EXIT_V0);
    bad_type = push && (bus.ret_is_i_i == bus.ret_is_r_i);
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    entry_in.pc    = bus.ret_pc_i;
    entry_in.instr = bus.ret_instr_i;
    entry_in.typ   = {bus.ret_is_i_i, bus.ret_is_r_i};
    entry_in.dest  = bus.ret_dest_i;
    entry_in.val   = bus.ret_dest_val_i;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    entry_in.cyc   = cyc_cnt;
`endif
  end

  always_comb begin
    state_next = state;
    eos        = 1'b0;
    case (state)
      RUN:     if (is_exit) state_next = DRAIN;
      DRAIN:   if (count_next == '0) state_next = DONE;
      DONE: begin
        state_next = DONE;
        eos        = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      stall      <= 1'b0;
      overflow   <= 1'b0;
      type_err   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (push) begin
        wptr       <= wptr + PTR_W'(1);
        retire_cnt <= sat_inc(retire_cnt);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      count <= count_next;
      stall <= (count_next >= STALL_CNT);
      if (drop)     overflow <= 1'b1;
      if (bad_type) type_err <= 1'b1;
    end
  end

`ifdef RETIRE_TRACE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (!reset) cyc_cnt <= '0;
    else        cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  // Storage is not reset; the head is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= entry_in;
  end

  assign head = empty ? '0 : mem[rptr];

  assign bus.trc_valid_o    = !empty;
  assign bus.trc_pc_o       = head.pc;
  assign bus.trc_instr_o    = head.instr;
  assign bus.trc_dest_val_o = head.val;
  assign bus.trc_dest_o     = head.dest;
  assign bus.trc_type_o     = head.typ;
  assign bus.stall_o        = stall;
  assign bus.overflow_o     = overflow;
  assign bus.type_err_o     = type_err;
  assign bus.eos_o          = eos;
  assign bus.retire_cnt_o   = retire_cnt;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
  assign bus.trc_cycle_o    = head.cyc;
`endif
endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed self-checking bench for retire_trace_buf (DEPTH=8, CNT_W=32).
module tb_retire_trace_buf;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  retire_trace_buf_if #(.CNT_W(32)) bus ();
  retire_trace_buf #(.DEPTH(8), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [4:0]  exp_dest;
    logic        exp_stall;
    logic        exp_ovf;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ret_valid_i    = 1'b0;
    bus.ret_pc_i       = '0;
    bus.ret_instr_i    = '0;
    bus.ret_is_r_i     = 1'b0;
    bus.ret_is_i_i     = 1'b0;
    bus.ret_dest_i     = '0;
    bus.ret_dest_val_i = '0;
    bus.ret_v0_i       = '0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [1:0] typ,
                        input logic [4:0] dest, input logic [31:0] val, input logic [31:0] v0);
    bus.ret_valid_i    = 1'b1;
    bus.ret_pc_i       = pc;
    bus.ret_instr_i    = instr;
    bus.ret_is_i_i     = typ[1];
    bus.ret_is_r_i     = typ[0];
    bus.ret_dest_i     = dest;
    bus.ret_dest_val_i = val;
    bus.ret_v0_i       = v0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    bus.trc_ready_i = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.trc_valid_o), 32'd0);
    chk({tag, "_pc"},    bus.trc_pc_o, 32'd0);
    chk({tag, "_instr"}, bus.trc_instr_o, 32'd0);
    chk({tag, "_val"},   bus.trc_dest_val_o, 32'd0);
    chk({tag, "_dest"},  32'(bus.trc_dest_o), 32'd0);
    chk({tag, "_type"},  32'(bus.trc_type_o), 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
    chk({tag, "_ovf"},   32'(bus.overflow_o), 32'd0);
    chk({tag, "_terr"},  32'(bus.type_err_o), 32'd0);
    chk({tag, "_eos"},   32'(bus.eos_o), 32'd0);
    chk({tag, "_cnt"},   bus.retire_cnt_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill 9 (last one dropped), then drain 8 with ready high.
    for (int i = 0; i < 9; i++) begin
      vecs[i].valid     = 1'b1;
      vecs[i].pc        = 32'h100 + 32'(4 * i);
      vecs[i].dest      = 5'(i);
      vecs[i].ready     = 1'b0;
      vecs[i].exp_valid = 1'b1;
      vecs[i].exp_pc    = 32'h100;
      vecs[i].exp_dest  = 5'd0;
      vecs[i].exp_stall = (i >= 5);
      vecs[i].exp_ovf   = (i == 8);
      vecs[i].exp_cnt   = (i < 8) ? 32'(i + 1) : 32'd8;
    end
    for (int k = 0; k < 8; k++) begin
      vecs[9+k].valid     = 1'b0;
      vecs[9+k].pc        = 32'd0;
      vecs[9+k].dest      = 5'd0;
      vecs[9+k].ready     = 1'b1;
      vecs[9+k].exp_valid = (k < 7);
      vecs[9+k].exp_pc    = (k < 7) ? 32'h100 + 32'(4 * (k + 1)) : 32'd0;
      vecs[9+k].exp_dest  = (k < 7) ? 5'(k + 1) : 5'd0;
      vecs[9+k].exp_stall = (k < 2);
      vecs[9+k].exp_ovf   = 1'b1;
      vecs[9+k].exp_cnt   = 32'd8;
    end

    idle();
    bus.trc_ready_i = 1'b0;
    tick();
    do_reset();
    chk_all_zero("reset");

    // Single retire, ready held high.
    bus.trc_ready_i = 1'b1;
    retire(32'h00400000, 32'h01095020, 2'b01, 5'd10, 32'h5, 32'h0);
    chk("single_nobypass", 32'(bus.trc_valid_o), 32'd0);
    tick();
    idle();
    chk("single_valid", 32'(bus.trc_valid_o), 32'd1);
    chk("single_pc",    bus.trc_pc_o, 32'h00400000);
    chk("single_instr", bus.trc_instr_o, 32'h01095020);
    chk("single_type",  32'(bus.trc_type_o), 32'd1);
    chk("single_dest",  32'(bus.trc_dest_o), 32'd10);
    chk("single_val",   bus.trc_dest_val_o, 32'h5);
    chk("single_cnt",   bus.retire_cnt_o, 32'd1);
    chk("single_terr",  32'(bus.type_err_o), 32'd0);
    tick();
    chk("single_gone",  32'(bus.trc_valid_o), 32'd0);

    // Table: fill, overflow, drain in order.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].valid)
        retire(vecs[i].pc, 32'h20000000 | 32'(i), 2'b10, vecs[i].dest, 32'(i), 32'd0);
      else
        idle();
      bus.trc_ready_i = vecs[i].ready;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.trc_valid_o), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_pc", i),    bus.trc_pc_o, vecs[i].exp_pc);
      chk($sformatf("vec%0d_dest", i),  32'(bus.trc_dest_o), 32'(vecs[i].exp_dest));
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall_o), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_ovf", i),   32'(bus.overflow_o), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_cnt", i),   bus.retire_cnt_o, vecs[i].exp_cnt);
    end
    idle();
    bus.trc_ready_i = 1'b0;

    // Full FIFO with simultaneous pop and push.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      retire(32'h200 + 32'(4 * i), 32'h20000000, 2'b10, 5'd1, 32'd0, 32'd0);
      tick();
    end
    chk("hold_pc", bus.trc_pc_o, 32'h200);
    retire(32'h300, 32'h20000000, 2'b10, 5'd1, 32'd0, 32'd0);
    bus.trc_ready_i = 1'b1;
    tick();
    idle();
    chk("pp_ovf",   32'(bus.overflow_o), 32'd0);
    chk("pp_cnt",   bus.retire_cnt_o, 32'd9);
    chk("pp_stall", 32'(bus.stall_o), 32'd1);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("pp_head%0d", k), bus.trc_pc_o, 32'h200 + 32'(4 * k));
      tick();
    end
    chk("pp_last", bus.trc_pc_o, 32'h300);
    tick();
    chk("pp_empty", 32'(bus.trc_valid_o), 32'd0);

    // Exit syscall, trailing retires ignored, then drain to EOS.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      retire(32'h400 + 32'(4 * i), 32'h20000000, 2'b10, 5'd2, 32'd0, 32'd0);
      tick();
    end
    retire(32'h40c, 32'h0000000c, 2'b01, 5'd0, 32'd0, 32'h0000000a);
    tick();
    for (int i = 0; i < 2; i++) begin
      retire(32'h500, 32'h20000000, 2'b10, 5'd2, 32'd0, 32'd0);
      tick();
    end
    idle();
    chk("eos_cnt_pre", bus.retire_cnt_o, 32'd4);
    chk("eos_pre",     32'(bus.eos_o), 32'd0);
    bus.trc_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("eos_head%0d", k), bus.trc_pc_o, 32'h400 + 32'(4 * k));
      chk($sformatf("eos_early%0d", k), 32'(bus.eos_o), 32'd0);
      tick();
    end
    chk("eos_set",   32'(bus.eos_o), 32'd1);
    chk("eos_valid", 32'(bus.trc_valid_o), 32'd0);
    chk("eos_cnt",   bus.retire_cnt_o, 32'd4);
    chk("eos_ovf",   32'(bus.overflow_o), 32'd0);
    retire(32'h600, 32'h20000000, 2'b10, 5'd2, 32'd0, 32'd0);
    tick();
    idle();
    chk("done_cnt",   bus.retire_cnt_o, 32'd4);
    chk("done_valid", 32'(bus.trc_valid_o), 32'd0);
    chk("done_eos",   32'(bus.eos_o), 32'd1);

    // Bad type, then reset clears everything.
    do_reset();
    retire(32'h700, 32'h20000000, 2'b11, 5'd3, 32'd9, 32'd0);
    tick();
    idle();
    chk("bad_type", 32'(bus.trc_type_o), 32'd3);
    chk("bad_terr", 32'(bus.type_err_o), 32'd1);
    reset = 1'b0;
    tick();
    chk_all_zero("rst2");
    reset = 1'b1;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    do_reset();
    tick(); tick(); tick();
    retire(32'h800, 32'h20000000, 2'b10, 5'd1, 32'd0, 32'd0);
    tick();
    idle();
    tick(); tick(); tick();
    retire(32'h804, 32'h20000000, 2'b10, 5'd1, 32'd0, 32'd0);
    tick();
    idle();
    chk("ts_first", bus.trc_cycle_o, 32'd3);
    bus.trc_ready_i = 1'b1;
    tick();
    chk("ts_second", bus.trc_cycle_o, 32'd7);
    bus.trc_ready_i = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
